// File: rtl/dmc_pkg.sv
// Shared definitions for the direct-mapped cache: address-field width helpers,
// FSM states, command kinds and the response encoding used with DMC_Controller.
package dmc_pkg;

   typedef enum logic [0:0] {
      ST_INIT,
      ST_IDLE
   } state_t;

   typedef enum logic [2:0] {
      RSP_NONE,
      RSP_HIT,
      RSP_RD_FLUSH,
      RSP_RD_FETCH,
      RSP_WR_FLUSH,
      RSP_WR_FETCH
   } resp_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_READ,
      CMD_WRITE,
      CMD_RLINE,
      CMD_WLINE
   } cmd_t;

   function automatic int ofs_w(input int blocks_per_line);
      return $clog2(blocks_per_line);
   endfunction

   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_w(input int addr_size, input int blocks_per_line, input int num_lines);
      return addr_size - ofs_w(blocks_per_line) - idx_w(num_lines);
   endfunction

endpackage

// File: rtl/dmc_tag_store.sv
// Per-line tag, valid and dirty storage with a one-line-per-cycle clear port
// used by the INIT sweep; reads are combinational on idx_i.
module dmc_tag_store
   import dmc_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int IDX_W     = 2,
   parameter int TAG_W     = 26
)(
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] clr_idx_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             install_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             set_dirty_i,
   output logic [TAG_W-1:0] tag_o,
   output logic             valid_o,
   output logic             dirty_o
);

   logic [TAG_W-1:0]     tag_q [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q[clr_idx_i] <= 1'b0;
         dirty_q[clr_idx_i] <= 1'b0;
      end else if (install_i) begin
         tag_q[idx_i]   <= tag_i;
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (set_dirty_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   assign tag_o   = tag_q[idx_i];
   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];

endmodule

// File: rtl/dmc_cache_array.sv
// Direct-mapped cache array: lookup, line read/write and INIT sweep.
// Optional DMC_CACHE_STATS_EN adds saturating hit/miss/flush counters.
module dmc_cache_array
   import dmc_pkg::*;
#(
   parameter int BLOCK_SIZE             = 32,
   parameter int NUM_OF_BLOCKS_PER_LINE = 4,
   parameter int NUM_OF_CACHE_LINES     = 4,
   parameter int ADDRESS_SIZE           = 32
)(
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     read_i,
   input  logic                                     write_i,
   input  logic                                     read_line_i,
   input  logic                                     write_line_i,
   input  logic [ADDRESS_SIZE-1:0]                  address_i,
   input  logic [BLOCK_SIZE-1:0]                    data_i,
   input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_i,
   output logic [BLOCK_SIZE-1:0]                    data_o,
   output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_o,
   output logic [ADDRESS_SIZE-1:0]                  address_o,
   output logic                                     hit_o,
   output logic                                     read_flush_o,
   output logic                                     read_fetch_o,
   output logic                                     write_flush_o,
   output logic                                     write_fetch_o,
   output logic                                     ready_o
`ifdef DMC_CACHE_STATS_EN
   ,
   output logic [31:0]                              hit_count_o,
   output logic [31:0]                              miss_count_o,
   output logic [31:0]                              flush_count_o
`endif
);

   localparam int OFS_W = ofs_w(NUM_OF_BLOCKS_PER_LINE);
   localparam int IDX_W = idx_w(NUM_OF_CACHE_LINES);
   localparam int TAG_W = tag_w(ADDRESS_SIZE, NUM_OF_BLOCKS_PER_LINE, NUM_OF_CACHE_LINES);

   typedef logic [NUM_OF_BLOCKS_PER_LINE-1:0][BLOCK_SIZE-1:0] line_t;

   state_t                  state_q;
   logic [IDX_W-1:0]        init_cnt_q;
   logic                    ready_q;
   resp_t                   resp_q, resp_d;
   cmd_t                    pend_cmd_q;
   logic [ADDRESS_SIZE-1:0] pend_addr_q;
   logic [BLOCK_SIZE-1:0]   pend_data_q;
   line_t                   pend_line_q;
   logic [BLOCK_SIZE-1:0]   data_q;
   line_t                   line_q;
   logic [ADDRESS_SIZE-1:0] addr_q;
   line_t                   data_arr_q [NUM_OF_CACHE_LINES];

   cmd_t                    cmd_in, cmd;
   logic [ADDRESS_SIZE-1:0] cmd_addr;
   logic [BLOCK_SIZE-1:0]   cmd_data;
   line_t                   cmd_line;
   logic [OFS_W-1:0]        ofs;
   logic [IDX_W-1:0]        idx;
   logic [TAG_W-1:0]        tag;
   logic [TAG_W-1:0]        st_tag;
   logic                    st_valid, st_dirty;
   logic                    hit, active, install, set_dirty;

   always_comb begin
      cmd_in = CMD_NONE;
      if (write_line_i)     cmd_in = CMD_WLINE;
      else if (read_line_i) cmd_in = CMD_RLINE;
      else if (write_i)     cmd_in = CMD_WRITE;
      else if (read_i)      cmd_in = CMD_READ;
   end

   // A command parked during INIT takes the first IDLE slot.
   always_comb begin
      cmd      = cmd_in;
      cmd_addr = address_i;
      cmd_data = data_i;
      cmd_line = line_t'(line_i);
      if (pend_cmd_q != CMD_NONE) begin
         cmd      = pend_cmd_q;
         cmd_addr = pend_addr_q;
         cmd_data = pend_data_q;
         cmd_line = pend_line_q;
      end
   end

   assign ofs       = cmd_addr[OFS_W-1:0];
   assign idx       = cmd_addr[OFS_W +: IDX_W];
   assign tag       = cmd_addr[ADDRESS_SIZE-1 -: TAG_W];
   assign hit       = st_valid && (st_tag == tag);
   assign active    = (state_q == ST_IDLE) && !rst_i;
   assign install   = active && (cmd == CMD_WLINE);
   assign set_dirty = active && (cmd == CMD_WRITE) && hit;

   always_comb begin
      resp_d = RSP_NONE;
      if (state_q == ST_IDLE) begin
         case (cmd)
            CMD_READ:  resp_d = hit ? RSP_HIT : ((st_valid && st_dirty) ? RSP_RD_FLUSH : RSP_RD_FETCH);
            CMD_WRITE: resp_d = hit ? RSP_HIT : ((st_valid && st_dirty) ? RSP_WR_FLUSH : RSP_WR_FETCH);
            default:   resp_d = RSP_NONE;
         endcase
      end
   end

   dmc_tag_store #(
      .NUM_LINES (NUM_OF_CACHE_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_tags (
      .clk_i       (clk_i),
      .clr_i       (state_q == ST_INIT),
      .clr_idx_i   (init_cnt_q),
      .idx_i       (idx),
      .install_i   (install),
      .tag_i       (tag),
      .set_dirty_i (set_dirty),
      .tag_o       (st_tag),
      .valid_o     (st_valid),
      .dirty_o     (st_dirty)
   );

   always_ff @(posedge clk_i) begin
      if (install)        data_arr_q[idx]      <= cmd_line;
      else if (set_dirty) data_arr_q[idx][ofs] <= cmd_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         ready_q    <= 1'b0;
         resp_q     <= RSP_NONE;
         pend_cmd_q <= CMD_NONE;
         data_q     <= '0;
         line_q     <= '0;
         addr_q     <= '0;
      end else begin
         resp_q <= resp_d;
         case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + IDX_W'(1);
               if (init_cnt_q == IDX_W'(NUM_OF_CACHE_LINES - 1)) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
               end
               if (pend_cmd_q == CMD_NONE) begin
                  pend_cmd_q  <= cmd_in;
                  pend_addr_q <= address_i;
                  pend_data_q <= data_i;
                  pend_line_q <= line_t'(line_i);
               end
            end
            default: begin
               pend_cmd_q <= CMD_NONE;
               if (cmd == CMD_READ && hit) data_q <= data_arr_q[idx][ofs];
               if (cmd == CMD_RLINE) begin
                  line_q <= data_arr_q[idx];
                  addr_q <= {st_tag, idx, OFS_W'(0)};
               end
            end
         endcase
      end
   end

   assign data_o        = data_q;
   assign line_o        = line_q;
   assign address_o     = addr_q;
   assign ready_o       = ready_q;
   assign hit_o         = (resp_q == RSP_HIT);
   assign read_flush_o  = (resp_q == RSP_RD_FLUSH);
   assign read_fetch_o  = (resp_q == RSP_RD_FETCH);
   assign write_flush_o = (resp_q == RSP_WR_FLUSH);
   assign write_fetch_o = (resp_q == RSP_WR_FETCH);

`ifdef DMC_CACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q, flush_cnt_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (resp_d == RSP_HIT) hit_cnt_q <= sat_inc(hit_cnt_q);
         if (resp_d == RSP_RD_FETCH || resp_d == RSP_WR_FETCH) miss_cnt_q <= sat_inc(miss_cnt_q);
         if (resp_d == RSP_RD_FLUSH || resp_d == RSP_WR_FLUSH) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   assign hit_count_o   = hit_cnt_q;
   assign miss_count_o  = miss_cnt_q;
   assign flush_count_o = flush_cnt_q;
`endif

endmodule
